// File: rtl/quad_adc_serializer_pkg.sv
// Shared constants and types for the quad ADC 2-lane serializer.
package quad_adc_serializer_pkg;

    localparam int SAMPLE_WIDTH     = 14;
    localparam int SLOTS            = 8;
    localparam int FRAME_HIGH_SLOTS = 4;
    localparam int DATA_PAIRS       = SAMPLE_WIDTH / 2;
    localparam int SLOT_W           = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t LAST_SLOT      = slot_t'(SLOTS - 1);
    localparam slot_t LAST_DATA_SLOT = slot_t'(DATA_PAIRS - 1);
    localparam slot_t FRAME_HIGH_END = slot_t'(FRAME_HIGH_SLOTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/quad_adc_serializer_lane.sv
// One channel's load/shift register: emits the MSB pair on load, then two
// bits per clock on shift; lanes drop to 0 on any cycle that is neither.
module quad_adc_serializer_lane
    import quad_adc_serializer_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    shift_i,
    input  logic [SAMPLE_WIDTH-1:0] data_i,
    output logic                    a_o,
    output logic                    b_o
);

    logic [SAMPLE_WIDTH-3:0] sr_q, sr_d;
    logic                    a_q, a_d;
    logic                    b_q, b_d;

    // Next lane bits: top pair straight from the sample on load, remainder from the shifter.
    always_comb begin
        sr_d = sr_q;
        a_d  = 1'b0;
        b_d  = 1'b0;
        if (load_i) begin
            a_d  = data_i[SAMPLE_WIDTH-1];
            b_d  = data_i[SAMPLE_WIDTH-2];
            sr_d = data_i[SAMPLE_WIDTH-3:0];
        end else if (shift_i) begin
            a_d  = sr_q[SAMPLE_WIDTH-3];
            b_d  = sr_q[SAMPLE_WIDTH-4];
            sr_d = {sr_q[SAMPLE_WIDTH-5:0], 2'b00};
        end
    end

    // Registered lane outputs and remaining bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
            a_q  <= 1'b0;
            b_q  <= 1'b0;
        end else begin
            sr_q <= sr_d;
            a_q  <= a_d;
            b_q  <= b_d;
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;

endmodule

// File: rtl/quad_adc_serializer.sv
// Quad ADC link transmitter: frames parallel samples into per-channel A/B
// bit pairs with forwarded DATA_CLK and FRAME_CLK. The FSM slot counter runs
// one cycle ahead of the registered outputs, so slot k is visible on the pins
// during the cycle after the FSM sits in slot k.
module quad_adc_serializer
    import quad_adc_serializer_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_BITS = 14
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] s_data_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    output logic                           data_clk_o,
    output logic                           frame_clk_o,
    output logic [NUM_CH-1:0]              ch_a_o,
    output logic [NUM_CH-1:0]              ch_b_o,
    output logic                           underrun_o,
    output logic                           busy_o
);

    if (SAMPLE_BITS != SAMPLE_WIDTH) begin : g_bad_width
        $error("quad_adc_serializer supports 14-bit samples only");
    end

    state_e state_q, state_d;
    slot_t  slot_q, slot_d;

    logic [NUM_CH*SAMPLE_WIDTH-1:0] hold_q, hold_d;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] last_q, last_d;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] load_word;
    logic                           full_q, full_d;

    logic run, load_slot, shift_slot, accept;
    logic data_clk_q, frame_clk_q, underrun_q, busy_q;
    logic underrun_d;

    // Frame sequencing: a frame, once started, always runs all slots.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        run        = (state_q == ST_RUN);
        load_slot  = run && (slot_q == '0);
        shift_slot = run && (slot_q != '0) && (slot_q <= LAST_DATA_SLOT);
        case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                if (enable_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (slot_q == LAST_SLOT) begin
                    slot_d = '0;
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    slot_d = slot_q + slot_t'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    // FSM state and slot counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // One-entry holding register; the slot-0 load frees it in the same edge
    // a new sample may enter, so full-rate streaming needs no bubble.
    always_comb begin
        s_ready_o  = !full_q || load_slot;
        accept     = s_valid_i && s_ready_o;
        load_word  = full_q ? hold_q : last_q;
        hold_d     = hold_q;
        full_d     = full_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        if (load_slot) begin
            last_d     = load_word;
            full_d     = 1'b0;
            underrun_d = !full_q;
        end
        if (accept) begin
            hold_d = s_data_i;
            full_d = 1'b1;
        end
    end

    // Holding, last-sample and registered status/clock outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= '0;
            full_q      <= 1'b0;
            last_q      <= '0;
            underrun_q  <= 1'b0;
            data_clk_q  <= 1'b0;
            frame_clk_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            full_q      <= full_d;
            last_q      <= last_d;
            underrun_q  <= underrun_d;
            data_clk_q  <= run && slot_q[0];
            frame_clk_q <= run && (slot_q < FRAME_HIGH_END);
            busy_q      <= run;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        quad_adc_serializer_lane u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (load_slot),
            .shift_i (shift_slot),
            .data_i  (load_word[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .a_o     (ch_a_o[c]),
            .b_o     (ch_b_o[c])
        );
    end

    assign data_clk_o  = data_clk_q;
    assign frame_clk_o = frame_clk_q;
    assign underrun_o  = underrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_quad_adc_serializer.sv
// Bench for quad_adc_serializer: frame-level reference model checked every
// cycle, plus a lane decoder whose results are pinned by literal expectations.
module tb_quad_adc_serializer;

    localparam int NCH = 4;
    localparam int W   = 14;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            s_valid = 1'b0;
    logic [NCH*W-1:0] s_data = '0;
    logic            s_ready, data_clk, frame_clk, underrun, busy;
    logic [NCH-1:0]  ch_a, ch_b;

    int checks = 0;
    int failures = 0;

    quad_adc_serializer #(.NUM_CH(NCH), .SAMPLE_BITS(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .data_clk_o  (data_clk),
        .frame_clk_o (frame_clk),
        .ch_a_o      (ch_a),
        .ch_b_o      (ch_b),
        .underrun_o  (underrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    logic [NCH*W-1:0] m_q[$];
    logic [NCH*W-1:0] m_last, m_cur;
    int               m_pos = -1;   // slot shown after this edge, -1 when idle
    bit               m_start = 0;  // next edge shows slot 0 of a new frame
    logic [NCH-1:0]   e_a = '0, e_b = '0;
    logic             e_dclk = 0, e_fclk = 0, e_busy = 0, e_und = 0, e_rdy = 1;

    always @(posedge clk or negedge rst_n) begin : model
        logic [NCH*W-1:0] word;
        bit rdy, acc;
        if (!rst_n) begin
            m_q.delete();
            m_last = '0; m_cur = '0; m_pos = -1; m_start = 0;
            e_a = '0; e_b = '0; e_dclk = 0; e_fclk = 0; e_busy = 0; e_und = 0; e_rdy = 1;
        end else begin
            rdy   = (m_q.size() == 0) || m_start;
            acc   = s_valid && rdy;
            e_und = 0;
            if (m_start) begin
                if (m_q.size() > 0) word = m_q.pop_front();
                else begin word = m_last; e_und = 1; end
                m_last = word;
                m_cur  = word;
                m_pos  = 0;
            end else if (m_pos >= 0 && m_pos < 7) m_pos++;
            else m_pos = -1;
            if (acc) m_q.push_back(s_data);
            m_start = enable && (m_pos == -1 || m_pos == 7);
            e_a = '0; e_b = '0; e_dclk = 0; e_fclk = 0; e_busy = 0;
            if (m_pos >= 0) begin
                e_busy = 1;
                e_dclk = (m_pos % 2) == 1;
                e_fclk = m_pos < 4;
                if (m_pos < 7)
                    for (int c = 0; c < NCH; c++) begin
                        e_a[c] = m_cur[c*W + 13 - 2*m_pos];
                        e_b[c] = m_cur[c*W + 12 - 2*m_pos];
                    end
            end
            e_rdy = (m_q.size() == 0) || m_start;
        end
    end

    // ---------------- per-cycle compare and lane decoder ----------------
    int         dec_k = -1;
    logic       prev_fclk = 0;
    logic [W-1:0] acc0 = '0, acc3 = '0;
    logic [W-1:0] dec0[$], dec3[$];
    int         und_cnt = 0;
    bit         pad_bad = 0;
    int         cyc = 0;
    int         last_rise = -1;
    int         periods[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            checks++;
            if ({ch_a, ch_b, data_clk, frame_clk, busy, underrun, s_ready} !==
                {e_a, e_b, e_dclk, e_fclk, e_busy, e_und, e_rdy}) begin
                failures++;
                $display("FAIL cycle_model t=%0t actual a=%b b=%b dclk=%b fclk=%b busy=%b und=%b rdy=%b required a=%b b=%b dclk=%b fclk=%b busy=%b und=%b rdy=%b",
                         $time, ch_a, ch_b, data_clk, frame_clk, busy, underrun, s_ready,
                         e_a, e_b, e_dclk, e_fclk, e_busy, e_und, e_rdy);
            end
            if (underrun) und_cnt++;
            if (frame_clk && !prev_fclk) begin
                dec_k = 0;
                if (last_rise >= 0) periods.push_back(cyc - last_rise);
                last_rise = cyc;
            end else if (busy && dec_k >= 0) dec_k++;
            else dec_k = -1;
            if (!busy) last_rise = -1;
            if (dec_k >= 0 && dec_k < 7) begin
                acc0[13-2*dec_k] = ch_a[0];
                acc0[12-2*dec_k] = ch_b[0];
                acc3[13-2*dec_k] = ch_a[3];
                acc3[12-2*dec_k] = ch_b[3];
                if (dec_k == 6) begin
                    dec0.push_back(acc0);
                    dec3.push_back(acc3);
                end
            end
            if (dec_k == 7 && (ch_a != '0 || ch_b != '0)) pad_bad = 1;
            prev_fclk = frame_clk;
        end else begin
            dec_k = -1;
            prev_fclk = 0;
            last_rise = -1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [NCH*W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 100; i++) begin
            if (s_ready) begin
                @(negedge clk);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 1, 0);
        s_valid = 1'b0;
    endtask

    task automatic wait_dec(input int n);
        for (int i = 0; i < 300; i++) begin
            if (dec0.size() >= n) return;
            @(negedge clk);
        end
        chk("wait_dec_timeout", dec0.size(), n);
    endtask

    task automatic wait_slot(input int k);
        for (int i = 0; i < 100; i++) begin
            if (dec_k == k) return;
            @(negedge clk);
        end
        chk("wait_slot_timeout", dec_k, k);
    endtask

    task automatic clear_dec();
        dec0.delete();
        dec3.delete();
        periods.delete();
        pad_bad = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int u0, n;
        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_lanes", {ch_a, ch_b, data_clk, frame_clk}, 0);

        // Back-to-back ch0 = 1..7
        clear_dec();
        u0 = und_cnt;
        enable = 1'b1;
        for (int i = 1; i <= 7; i++) send({42'b0, 14'(i)});
        wait_dec(7);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("seq_count", dec0.size(), 7);
        for (int i = 0; i < 7 && i < dec0.size(); i++) chk("seq_value", dec0[i], i + 1);
        chk("seq_underrun", und_cnt - u0, 0);
        chk("fclk_period_count", periods.size(), 6);
        foreach (periods[i]) chk("fclk_period", periods[i], 8);

        // Alternating patterns on ch0 / ch3
        clear_dec();
        u0 = und_cnt;
        enable = 1'b1;
        send({14'h1555, 14'h0, 14'h0, 14'h2AAA});
        wait_dec(1);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("pat_ch0", (dec0.size() > 0) ? dec0[0] : 14'h0, 14'h2AAA);
        chk("pat_ch3", (dec3.size() > 0) ? dec3[0] : 14'h0, 14'h1555);
        chk("pat_pad_zero", pad_bad, 0);
        chk("pat_underrun", und_cnt - u0, 0);

        // Single sample then starvation: repeat plus one underrun
        clear_dec();
        u0 = und_cnt;
        enable = 1'b1;
        send({42'b0, 14'h3FFF});
        wait_dec(2);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("repeat_count", dec0.size(), 2);
        chk("repeat_first", (dec0.size() > 0) ? dec0[0] : 14'h0, 14'h3FFF);
        chk("repeat_second", (dec0.size() > 1) ? dec0[1] : 14'h0, 14'h3FFF);
        chk("repeat_underrun", und_cnt - u0, 1);

        // ENABLE dropped at slot 3: frame completes
        clear_dec();
        enable = 1'b1;
        send({42'b0, 14'h0123});
        wait_slot(3);
        enable = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk("drop_tail_slots", n, 4);
        chk("drop_idle_outputs", {ch_a, ch_b, data_clk, frame_clk, busy}, 0);
        chk("drop_value", (dec0.size() > 0) ? dec0[0] : 14'h0, 14'h0123);

        // Async reset mid-frame discards the pending sample
        clear_dec();
        enable = 1'b1;
        send({42'b0, 14'h0ABC});
        send({42'b0, 14'h0155});
        wait_slot(2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {ch_a, ch_b, data_clk, frame_clk, busy, underrun}, 0);
        chk("rst_ready", s_ready, 1);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_dec();
        u0 = und_cnt;
        enable = 1'b1;
        wait_dec(1);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_value", (dec0.size() > 0) ? dec0[0] : 14'h3FFF, 14'h0);
        chk("post_rst_underrun", und_cnt - u0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
